// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/valid handshake,
// holds the instruction in EXEC and selects the next PC from Jump/Branch/Zero_flag.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero_flag,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EXEC, S_FAULT} state_e;

  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        fault_q, fault_d;
  logic [31:0] npc;
  logic        npc_bad;

  function automatic logic [31:0] next_pc_f(input logic jump, input logic branch,
                                            input logic zero, input logic [31:0] pc4,
                                            input logic [31:0] ins);
    logic signed [31:0] br_off;
    br_off = {{14{ins[15]}}, ins[15:0], 2'b00};
    if (jump)
      return {pc4[31:28], ins[25:0], 2'b00};
    else if (branch && zero)
      return pc4 + $unsigned(br_off);
    else
      return pc4;
  endfunction

  function automatic logic out_of_range_f(input logic [31:0] addr);
    return ({1'b0, addr} >= PC_LIMIT) || (addr[1:0] != 2'b00);
  endfunction

  assign pc_plus4 = pc_q + 32'd4;
  assign npc      = next_pc_f(Jump, Branch, Zero_flag, pc_plus4, instr_q);
  assign npc_bad  = out_of_range_f(npc);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      // Responses arriving in REQ are stale (e.g. issued before a reset) and dropped.
      S_REQ:   if (imem_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d = npc;
          if (npc_bad) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fault       = fault_q;
  assign instr_valid = (state_q == S_EXEC);
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign shamt       = instr_q[10:6];
  assign funct       = instr_q[5:0];
  assign imm         = instr_q[15:0];

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch unit for the MIPS single-cycle core. It owns the program counter and issues word reads to instruction memory over a request/response handshake. It holds each returned instruction stable and splits it into the fields the control unit decodes (opcode, funct) and the datapath uses (rs, rt, rd, shamt, imm). It consumes the control unit's Jump decision, plus Branch and Zero_flag, to select the next PC.

## Interface

Parameters
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (word aligned).
- IMEM_DEPTH, 1024, instruction memory size in 32-bit words; the valid PC range is 0 to IMEM_DEPTH*4-4.

Ports
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  byte address of the request; always equals pc.
- imem_ready  in  1  memory accepts the request in this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- Jump  in  1  from the control unit.
- Branch  in  1  conditional branch decoded.
- Zero_flag  in  1  ALU zero result.
- stall  in  1  holds the current instruction in EXEC.
- instr  out  32  latched instruction word.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm  out  16  instr[15:0].
- instr_valid  out  1  fields are valid; high only in EXEC.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, combinational.
- fault  out  1  sticky flag: next PC is out of range.

## Operation

- **Reset values:** pc=RESET_PC, instr=0 (all field outputs 0), instr_valid=0, imem_req=0, fault=0, state=IDLE.
- **States:** IDLE, REQ, WAIT, EXEC, FAULT.
- **IDLE:** lasts one cycle after reset is released, then moves to REQ.
- **REQ:**
  - imem_req=1 and imem_addr=pc.
  - On imem_ready=1, move to WAIT.
  - imem_rvalid is ignored in REQ; this drops stale responses after a reset.
- **WAIT:**
  - imem_req=0.
  - On imem_rvalid=1, latch instr=imem_rdata and move to EXEC.
  - No timeout.
- **EXEC:**
  - instr_valid=1; instr and pc are held stable.
  - If stall=1, stay in EXEC and ignore Jump, Branch and Zero_flag.
  - If stall=0, update pc and go to REQ, or to FAULT if the new PC is out of range.
- **Next-PC priority:**
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else Branch=1 and Zero_flag=1: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), 32-bit wrap-around arithmetic.
  - else: pc_plus4.
- **Range check:**
  - Out of range means next PC >= IMEM_DEPTH*4 (unsigned), or next PC[1:0] != 0.
  - On violation, pc keeps the faulting value and fault=1.
- **FAULT:** imem_req=0 and instr_valid=0. Stays there until rst_n=0.
- **Reset mid-operation:** rst_n=0 in any state forces the reset values on the next edge, including during WAIT with a response outstanding.

## Timing

- Minimum fetch latency: REQ accepted in cycle n, imem_rvalid in cycle n+1, EXEC in cycle n+2. This gives 3 cycles per instruction with zero memory wait and no stall.
- The earliest legal imem_rvalid is the cycle after acceptance. The memory must never assert imem_rvalid in the acceptance cycle.
- instr_valid, instr and all field outputs change only on the edge entering or leaving EXEC. The fields hold their last values outside EXEC.
- Jump, Branch and Zero_flag are sampled only on the edge that leaves EXEC (stall=0).
- imem_req is registered: it rises on the edge entering REQ and falls on the edge following acceptance.

## Test plan

- **Straight-line fetch:** rst_n low 2 cycles, memory with ready=1 and 1-cycle rvalid; words 0x20080005 and 0x01095020.
  - Required: first imem_addr=0x0; EXEC shows opcode=0x08 and imm=0x0005.
  - Required: second imem_addr=0x4 with funct=0x20, rd=10; EXEC entries 3 cycles apart.
- **Jump:** instr=0x08000010 at pc=0x8 with Jump=1 in EXEC. Required: next imem_addr=0x40.
- **Branch:**
  - Branch=1, Zero_flag=1, imm=0xFFFE at pc=0x20 → next pc=0x1C.
  - Same instruction with Zero_flag=0 → next pc=0x24.
  - Jump=1 and Branch=1 together → the jump target wins.
- **Handshake backpressure and stall:**
  - imem_ready low 3 cycles: imem_req stays high and imem_addr stable.
  - rvalid 4 cycles after acceptance: instr_valid rises the cycle after rvalid.
  - stall=1 for 5 cycles in EXEC: pc and instr unchanged, no new request.
- **Fault:** IMEM_DEPTH=16 with pc=0x3C executing a non-branch. Required: fault=1, imem_req stays 0, pc=0x40; only rst_n=0 clears it.
- **Reset in WAIT:** assert rst_n=0 while a response is outstanding, then deliver rvalid during the first REQ cycle after reset. Required: the response is ignored, instr stays 0, and imem_addr=RESET_PC.
